// File: rtl/queue_pkg.sv
// Shared sizing helpers and mode enum for the valid/ready queue family.
package queue_pkg;

    typedef enum logic [1:0] {
        Q_NORMAL = 2'd0,
        Q_PIPE   = 2'd1,
        Q_BYPASS = 2'd2
    } queue_mode_e;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/queue_wrap_ptr.sv
// Circular pointer register with explicit wrap at DEPTH-1, so any depth works.
module queue_wrap_ptr
    import queue_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        inc,
    output logic [ptr_width(DEPTH)-1:0] ptr
);

    localparam int PW = ptr_width(DEPTH);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/flow_queue.sv
// Parametrised valid/ready FIFO with optional pipe and bypass modes,
// synchronous flush, occupancy count and registered almost-full flag.
module flow_queue
    import queue_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int PIPE         = 0,
    parameter int BYPASS       = 0,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [WIDTH-1:0]            recv_msg,
    input  logic                        recv_val,
    output logic                        recv_rdy,
    output logic [WIDTH-1:0]            send_msg,
    output logic                        send_val,
    input  logic                        send_rdy,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        almost_full
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam bit PIPE_EN   = (PIPE != 0);
    localparam bit BYPASS_EN = (BYPASS != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             almost_full_q;
    logic             almost_full_d;
    logic             empty;
    logic             full;
    logic             enq;
    logic             deq;
    logic             bypass_xfer;
    logic             wr_en;
    logic             head_inc;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign recv_rdy = !clear && (!full || (PIPE_EN && send_rdy));
    assign send_val = !clear && (!empty || (BYPASS_EN && recv_val));
    assign send_msg = (BYPASS_EN && empty) ? recv_msg : mem[head];

    assign enq = recv_val && recv_rdy;
    assign deq = send_val && send_rdy;

    // A bypassed message never touches storage or the pointers.
    assign bypass_xfer = BYPASS_EN && empty && enq && deq;
    assign wr_en       = enq && !bypass_xfer;
    assign head_inc    = deq && !bypass_xfer;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (wr_en && !head_inc) begin
            count_d = count_q + CW'(1);
        end else if (head_inc && !wr_en) begin
            count_d = count_q - CW'(1);
        end
        almost_full_d = (int'(count_d) >= AFULL_THRESH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            almost_full_q <= almost_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tail] <= recv_msg;
        end
    end

    queue_wrap_ptr #(.DEPTH(DEPTH)) u_head_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (head_inc),
        .ptr   (head)
    );

    queue_wrap_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (wr_en),
        .ptr   (tail)
    );

    assign count       = count_q;
    assign almost_full = almost_full_q;

endmodule

// File: tb/tb_flow_queue.sv
// Directed bench for flow_queue: normal, pipe and bypass instances share one stimulus bus.
module tb_flow_queue;

    logic       clk;
    logic       reset;
    logic       clear;
    logic [7:0] recv_msg;
    logic       recv_val;
    logic       send_rdy;

    logic       n_recv_rdy, p_recv_rdy, b_recv_rdy;
    logic [7:0] n_send_msg, p_send_msg, b_send_msg;
    logic       n_send_val, p_send_val, b_send_val;
    logic [2:0] n_count, p_count, b_count;
    logic       n_afull, p_afull, b_afull;

    int n_checks = 0;
    int n_fail   = 0;

    flow_queue #(.WIDTH(8), .DEPTH(5), .PIPE(0), .BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .clear(clear),
        .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(n_recv_rdy),
        .send_msg(n_send_msg), .send_val(n_send_val), .send_rdy(send_rdy),
        .count(n_count), .almost_full(n_afull)
    );

    flow_queue #(.WIDTH(8), .DEPTH(5), .PIPE(1), .BYPASS(0)) dut_p (
        .clk(clk), .reset(reset), .clear(clear),
        .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(p_recv_rdy),
        .send_msg(p_send_msg), .send_val(p_send_val), .send_rdy(send_rdy),
        .count(p_count), .almost_full(p_afull)
    );

    flow_queue #(.WIDTH(8), .DEPTH(5), .PIPE(0), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .clear(clear),
        .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(b_recv_rdy),
        .send_msg(b_send_msg), .send_val(b_send_val), .send_rdy(send_rdy),
        .count(b_count), .almost_full(b_afull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        recv_val = 1'b0;
        send_rdy = 1'b0;
        clear    = 1'b0;
        recv_msg = 8'h00;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Pushes n entries base, base+1, ... with the send side stalled.
    task automatic fill(input int n, input logic [7:0] base);
        send_rdy = 1'b0;
        recv_val = 1'b1;
        for (int i = 0; i < n; i++) begin
            recv_msg = base + 8'(i);
            tick();
        end
        recv_val = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (n_count !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_count: got %0d expected 0", n_count);
        end
        n_checks++;
        if (n_recv_rdy !== 1'b1 || n_send_val !== 1'b0 || n_afull !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: rdy=%b val=%b afull=%b expected 1 0 0",
                     n_recv_rdy, n_send_val, n_afull);
        end
        recv_val = 1'b1;
        #1;
        n_checks++;
        if (b_send_val !== 1'b1 || n_send_val !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_send_val: bypass=%b normal=%b expected 1 0",
                     b_send_val, n_send_val);
        end
        recv_val = 1'b0;
        #1;
    endtask

    task automatic test_fill_drain();
        do_reset();
        send_rdy = 1'b0;
        recv_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            recv_msg = 8'h11 + 8'(i);
            #1;
            n_checks++;
            if (n_recv_rdy !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL fill_rdy[%0d]: got %b expected 1", i, n_recv_rdy);
            end
            tick();
            n_checks++;
            if (n_count !== 3'(i + 1) || n_afull !== ((i + 1) >= 3)) begin
                n_fail++;
                $display("[TB] FAIL fill_count[%0d]: count=%0d afull=%b expected %0d %b",
                         i, n_count, n_afull, i + 1, ((i + 1) >= 3));
            end
        end
        n_checks++;
        if (n_recv_rdy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL full_rdy: got %b expected 0", n_recv_rdy);
        end
        recv_val = 1'b0;
        send_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (n_send_val !== 1'b1 || n_send_msg !== 8'h11 + 8'(i)) begin
                n_fail++;
                $display("[TB] FAIL drain[%0d]: val=%b msg=%h expected 1 %h",
                         i, n_send_val, n_send_msg, 8'h11 + 8'(i));
            end
            tick();
        end
        n_checks++;
        if (n_count !== 3'd0 || n_send_val !== 1'b0 || n_afull !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL drained: count=%0d val=%b afull=%b expected 0 0 0",
                     n_count, n_send_val, n_afull);
        end
        send_rdy = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        fill(2, 8'h20);
        recv_val = 1'b1;
        send_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            recv_msg = 8'h22 + 8'(i);
            #1;
            n_checks++;
            if (n_send_msg !== 8'h20 + 8'(i)) begin
                n_fail++;
                $display("[TB] FAIL wrap_msg[%0d]: got %h expected %h",
                         i, n_send_msg, 8'h20 + 8'(i));
            end
            tick();
            n_checks++;
            if (n_count !== 3'd2) begin
                n_fail++;
                $display("[TB] FAIL wrap_count[%0d]: got %0d expected 2", i, n_count);
            end
        end
        recv_val = 1'b0;
        send_rdy = 1'b0;
    endtask

    task automatic test_pipe();
        logic [7:0] exp_seq [5];
        exp_seq[0] = 8'h12;
        exp_seq[1] = 8'h13;
        exp_seq[2] = 8'h14;
        exp_seq[3] = 8'h15;
        exp_seq[4] = 8'hA0;
        do_reset();
        fill(5, 8'h11);
        recv_val = 1'b1;
        send_rdy = 1'b1;
        recv_msg = 8'hA0;
        #1;
        n_checks++;
        if (p_recv_rdy !== 1'b1 || p_send_msg !== 8'h11) begin
            n_fail++;
            $display("[TB] FAIL pipe_rdy: rdy=%b msg=%h expected 1 11", p_recv_rdy, p_send_msg);
        end
        n_checks++;
        if (n_recv_rdy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL nopipe_rdy: got %b expected 0", n_recv_rdy);
        end
        tick();
        recv_val = 1'b0;
        #1;
        n_checks++;
        if (p_count !== 3'd5) begin
            n_fail++;
            $display("[TB] FAIL pipe_count: got %0d expected 5", p_count);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (p_send_val !== 1'b1 || p_send_msg !== exp_seq[i]) begin
                n_fail++;
                $display("[TB] FAIL pipe_drain[%0d]: val=%b msg=%h expected 1 %h",
                         i, p_send_val, p_send_msg, exp_seq[i]);
            end
            tick();
        end
        send_rdy = 1'b0;
    endtask

    task automatic test_bypass();
        do_reset();
        recv_msg = 8'h3C;
        recv_val = 1'b1;
        send_rdy = 1'b1;
        #1;
        n_checks++;
        if (b_send_val !== 1'b1 || b_send_msg !== 8'h3C) begin
            n_fail++;
            $display("[TB] FAIL bypass_same_cycle: val=%b msg=%h expected 1 3c",
                     b_send_val, b_send_msg);
        end
        n_checks++;
        if (n_send_val !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL nobypass_val: got %b expected 0", n_send_val);
        end
        tick();
        recv_val = 1'b0;
        #1;
        n_checks++;
        if (b_count !== 3'd0 || b_send_val !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bypass_after: count=%0d val=%b expected 0 0", b_count, b_send_val);
        end
        send_rdy = 1'b0;
    endtask

    task automatic test_clear();
        do_reset();
        fill(3, 8'h41);
        clear    = 1'b1;
        recv_val = 1'b1;
        send_rdy = 1'b1;
        recv_msg = 8'h99;
        #1;
        n_checks++;
        if (n_recv_rdy !== 1'b0 || n_send_val !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_gate: rdy=%b val=%b expected 0 0", n_recv_rdy, n_send_val);
        end
        tick();
        clear    = 1'b0;
        recv_val = 1'b0;
        #1;
        n_checks++;
        if (n_count !== 3'd0 || n_send_val !== 1'b0 || n_recv_rdy !== 1'b1 || n_afull !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_after: count=%0d val=%b rdy=%b afull=%b expected 0 0 1 0",
                     n_count, n_send_val, n_recv_rdy, n_afull);
        end
        send_rdy = 1'b0;
        fill(1, 8'h55);
        n_checks++;
        if (n_send_msg !== 8'h55 || n_count !== 3'd1) begin
            n_fail++;
            $display("[TB] FAIL clear_refill: msg=%h count=%0d expected 55 1", n_send_msg, n_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill(4, 8'h61);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (n_count !== 3'd0 || n_send_val !== 1'b0 || n_recv_rdy !== 1'b1 || n_afull !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid: count=%0d val=%b rdy=%b afull=%b expected 0 0 1 0",
                     n_count, n_send_val, n_recv_rdy, n_afull);
        end
        #1;
        reset = 1'b0;
        tick();
        fill(2, 8'h77);
        n_checks++;
        if (n_send_msg !== 8'h77 || n_count !== 3'd2) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_first: msg=%h count=%0d expected 77 2", n_send_msg, n_count);
        end
    endtask

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        recv_msg = 8'h00;
        recv_val = 1'b0;
        send_rdy = 1'b0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_pipe();
        test_bypass();
        test_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
